// File: rtl/status_branch_unit.sv
// Holds the ALU Z/N/V status flags, resolves flag-conditioned branches and performs the
// optional link-register write through a req/ack handshake with a timeout.
module status_branch_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned LINK_REG = 31,
    parameter int unsigned TIMEOUT  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flag_valid,
    input  logic             flag_z,
    input  logic             flag_n,
    input  logic             flag_v,
    input  logic             br_valid,
    input  logic [2:0]       br_cond,
    input  logic             br_link,
    input  logic [WIDTH-1:0] br_target,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic             link_ack,
    output logic             statusZ,
    output logic             statusN,
    output logic             statusV,
    output logic             take_branch,
    output logic [WIDTH-1:0] pc_target,
    output logic             link_we,
    output logic [4:0]       link_addr,
    output logic [WIDTH-1:0] link_data,
    output logic             stall,
    output logic             link_err
);

    localparam int unsigned    CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [4:0]     LINK_ADDR = 5'(LINK_REG);

    typedef enum logic [0:0] {IDLE, LINK_WAIT} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          cond_true;

    // Branches see the flags held before this edge, never a same-cycle flag_valid.
    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            3'b000:  cond_true = 1'b0;
            3'b001:  cond_true = 1'b1;
            3'b010:  cond_true = statusZ;
            3'b011:  cond_true = !statusZ;
            3'b100:  cond_true = statusN;
            3'b101:  cond_true = statusN | statusZ;
            3'b110:  cond_true = statusV;
            default: cond_true = !statusN & !statusZ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            statusZ     <= 1'b0;
            statusN     <= 1'b0;
            statusV     <= 1'b0;
            take_branch <= 1'b0;
            pc_target   <= '0;
            link_we     <= 1'b0;
            link_addr   <= '0;
            link_data   <= '0;
            stall       <= 1'b0;
            link_err    <= 1'b0;
        end else begin
            take_branch <= 1'b0;
            link_err    <= 1'b0;
            if (flag_valid) begin
                statusZ <= flag_z;
                statusN <= flag_n;
                statusV <= flag_v;
            end
            case (state)
                IDLE: begin
                    if (br_valid && cond_true) begin
                        take_branch <= 1'b1;
                        pc_target   <= br_target;
                        if (br_link) begin
                            link_data <= pc_plus4;
                            link_we   <= 1'b1;
                            link_addr <= LINK_ADDR;
                            stall     <= 1'b1;
                            count     <= '0;
                            state     <= LINK_WAIT;
                        end
                    end
                end
                LINK_WAIT: begin
                    if (link_ack || count == CNT_LAST) begin
                        link_err  <= !link_ack;
                        link_we   <= 1'b0;
                        link_addr <= '0;
                        stall     <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_status_branch_unit.sv
// Directed self-checking bench for status_branch_unit; inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_status_branch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        flag_valid, flag_z, flag_n, flag_v;
    logic        br_valid, br_link, link_ack;
    logic [2:0]  br_cond;
    logic [31:0] br_target, pc_plus4;
    logic        statusZ, statusN, statusV, take_branch, link_we, stall, link_err;
    logic [31:0] pc_target, link_data;
    logic [4:0]  link_addr;

    int total = 0;
    int bad   = 0;

    status_branch_unit #(.WIDTH(32), .LINK_REG(31), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .flag_valid(flag_valid), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
        .br_valid(br_valid), .br_cond(br_cond), .br_link(br_link),
        .br_target(br_target), .pc_plus4(pc_plus4), .link_ack(link_ack),
        .statusZ(statusZ), .statusN(statusN), .statusV(statusV),
        .take_branch(take_branch), .pc_target(pc_target),
        .link_we(link_we), .link_addr(link_addr), .link_data(link_data),
        .stall(stall), .link_err(link_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Condition table written out term by term.
    function automatic logic exp_taken(input logic [2:0] c, input logic z, n, v);
        logic r;
        r = 1'b0;
        if (c == 3'd1) r = 1'b1;
        if (c == 3'd2 && z) r = 1'b1;
        if (c == 3'd3 && !z) r = 1'b1;
        if (c == 3'd4 && n) r = 1'b1;
        if (c == 3'd5 && (n || z)) r = 1'b1;
        if (c == 3'd6 && v) r = 1'b1;
        if (c == 3'd7 && !n && !z) r = 1'b1;
        return r;
    endfunction

    task automatic set_flags(input logic z, n, v);
        flag_valid = 1'b1; flag_z = z; flag_n = n; flag_v = v;
        tick();
        flag_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [2:0]  fl;
        logic [2:0]  cc;
        reset = 1'b1; flag_valid = 0; flag_z = 0; flag_n = 0; flag_v = 0;
        br_valid = 0; br_link = 0; link_ack = 0; br_cond = 3'd0;
        br_target = '0; pc_plus4 = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_take", take_branch, 0);
        chk("rst_pc", pc_target, 0);
        chk("rst_we", link_we, 0);
        chk("rst_addr", link_addr, 0);
        chk("rst_stall", stall, 0);
        chk("rst_flags", {statusZ, statusN, statusV}, 0);

        // 1: plain Z branch
        set_flags(1, 0, 0);
        chk("t1_z", statusZ, 1);
        br_valid = 1; br_cond = 3'b010; br_target = 32'h40;
        tick();
        br_valid = 0;
        chk("t1_take", take_branch, 1);
        chk("t1_pc", pc_target, 32'h40);
        chk("t1_we", link_we, 0);
        tick();
        chk("t1_pulse", take_branch, 0);
        chk("t1_hold", pc_target, 32'h40);

        // 2: same-cycle flag update does not affect the branch
        flag_valid = 1; flag_z = 0; br_valid = 1; br_cond = 3'b010; br_target = 32'h80;
        tick();
        flag_valid = 0; br_valid = 0;
        chk("t2_take", take_branch, 1);
        chk("t2_pc", pc_target, 32'h80);
        chk("t2_z", statusZ, 0);

        // 3: linking branch, ack in third LINK_WAIT cycle
        set_flags(0, 1, 0);
        br_valid = 1; br_cond = 3'b101; br_link = 1; pc_plus4 = 32'h100; br_target = 32'h200;
        tick();
        br_valid = 0; br_link = 0;
        chk("t3_take", take_branch, 1);
        chk("t3_we1", link_we, 1);
        chk("t3_stall1", stall, 1);
        chk("t3_addr", link_addr, 31);
        chk("t3_data", link_data, 32'h100);
        tick();
        chk("t3_we2", link_we, 1);
        tick();
        chk("t3_we3", link_we, 1);
        link_ack = 1;
        tick();
        link_ack = 0;
        chk("t3_we_off", link_we, 0);
        chk("t3_stall_off", stall, 0);
        chk("t3_addr_off", link_addr, 0);
        chk("t3_err", link_err, 0);
        chk("t3_data_hold", link_data, 32'h100);

        // 4: timeout after 8 cycles of link_we
        br_valid = 1; br_cond = 3'b001; br_link = 1; pc_plus4 = 32'h204; br_target = 32'h300;
        tick();
        br_valid = 0; br_link = 0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_we%0d", i), {link_we, stall, link_err}, 3'b110);
            tick();
        end
        chk("t4_err", link_err, 1);
        chk("t4_we_off", link_we, 0);
        chk("t4_stall_off", stall, 0);
        tick();
        chk("t4_err_pulse", link_err, 0);
        link_ack = 1;
        tick();
        link_ack = 0;
        chk("t4_idle_ack", {link_we, stall, link_err}, 0);

        // 5: reset in second LINK_WAIT cycle
        set_flags(1, 1, 1);
        br_valid = 1; br_cond = 3'b001; br_link = 1; pc_plus4 = 32'h404; br_target = 32'h400;
        tick();
        br_valid = 0; br_link = 0;
        tick();
        chk("t5_we", link_we, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("t5_outs", {take_branch, link_we, stall, link_err, link_addr}, 0);
        chk("t5_pc", pc_target, 0);
        chk("t5_data", link_data, 0);
        chk("t5_flags", {statusZ, statusN, statusV}, 0);
        br_valid = 1; br_cond = 3'b011; br_target = 32'h500;
        tick();
        br_valid = 0;
        chk("t5_take", take_branch, 1);
        chk("t5_pc2", pc_target, 32'h500);
        chk("t5_nolink", link_we, 0);

        // 6: condition sweep; a not-taken branch must leave pc_target alone
        exp_pc = 32'h500;
        for (int f = 0; f < 8; f++) begin
            fl = 3'(f);
            set_flags(fl[0], fl[1], fl[2]);
            for (int c = 0; c < 8; c++) begin
                cc = 3'(c);
                br_valid = 1; br_cond = cc; br_target = 32'h1000 + 32'(f * 16 + c) * 4;
                tick();
                br_valid = 0;
                if (exp_taken(cc, fl[0], fl[1], fl[2])) exp_pc = br_target;
                chk($sformatf("t6_take_f%0d_c%0d", f, c), take_branch,
                    32'(exp_taken(cc, fl[0], fl[1], fl[2])));
                chk($sformatf("t6_pc_f%0d_c%0d", f, c), pc_target, exp_pc);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
